// File: rtl/phrase_down_serializer_pkg.sv
// Shared types and beat-geometry helpers for the phrase down-serializer.
package bus_down_pkg;

  typedef enum logic [1:0] {SZ8 = 2'd0, SZ16 = 2'd1, SZ32 = 2'd2} size_e;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  // Reserved code 3 behaves as 32-bit; anything wider than the output bus clamps to it.
  function automatic int beat_bits(logic [1:0] size, int out_w);
    int b;
    case (size)
      SZ8:     b = 8;
      SZ16:    b = 16;
      default: b = 32;
    endcase
    if (b > out_w) b = out_w;
    return b;
  endfunction

  function automatic int nbeats(logic [1:0] size, int in_w, int out_w);
    return in_w / beat_bits(size, out_w);
  endfunction

  function automatic logic [31:0] lane_mask(logic [1:0] size, int out_w);
    logic [32:0] m;
    m = (33'd1 << beat_bits(size, out_w)) - 33'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/phrase_down_serializer_if.sv
// Phrase-in / beat-out handshake bundle for the down-serializer.
interface phrase_down_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 32
);
  localparam int BEAT_W = (IN_W > 8) ? $clog2(IN_W / 8) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [1:0]        in_size;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [BEAT_W-1:0] out_beat;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_size, abort, out_ready,
    input  in_ready, out_valid, out_data, out_beat, out_last
  );

  modport slave (
    input  in_valid, in_data, in_size, abort, out_ready,
    output in_ready, out_valid, out_data, out_beat, out_last
  );
endinterface

// File: rtl/phrase_down_serializer_fifo.sv
// Small synchronous FIFO holding {size, data} phrases; exposes head and the entry behind it.
module phrase_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [W-1:0]               nxt,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_q, rd_q, rd_nx;
  logic [CW-1:0] cnt_q;

  function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_nx = inc(rd_q);
  assign head  = mem[rd_q];
  // Lets the top start the following phrase on the same edge the head pops.
  assign nxt   = mem[rd_nx];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= inc(wr_q);
      if (pop)  rd_q <= rd_nx;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/phrase_down_serializer.sv
// Buffers whole phrases and replays each as a burst of lane-replicated narrow beats.
module phrase_down_serializer
  import bus_down_pkg::*;
#(
  parameter int IN_W    = 64,
  parameter int OUT_W   = 32,
  parameter int DEPTH   = 2,
  parameter int BIG_END = 0
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  phrase_down_serializer_if.slave bus
);
  localparam int BEAT_W = (IN_W > 8) ? $clog2(IN_W / 8) : 1;
  localparam int FW     = IN_W + 2;
  localparam int CW     = $clog2(DEPTH + 1);

  state_e                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [IN_W-1:0]          shreg_q;
  logic [1:0]               size_q;
  logic                     in_rdy, push, pop, load, load_next, full, empty, last;
  logic [FW-1:0]            head, nxt, load_word;
  logic [CW-1:0]            count;
  int                       bw, nb, k;
  logic [OUT_W-1:0]         lane;
  logic [OUT_W/8-1:0][7:0]  rep;

  // The abort cycle refuses pushes so nothing slips into the FIFO being flushed.
  assign in_rdy       = !full && !bus.abort;
  assign push         = bus.in_valid && in_rdy;
  assign bus.in_ready = in_rdy;

  phrase_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (reset),
    .flush (bus.abort),
    .push  (push),
    .din   ({bus.in_size, bus.in_data}),
    .pop   (pop),
    .head  (head),
    .nxt   (nxt),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    bw   = beat_bits(size_q, OUT_W);
    nb   = IN_W / bw;
    k    = (BIG_END != 0) ? nb - 1 - int'(beat_q) : int'(beat_q);
    last = (state_q == SEND) && (int'(beat_q) == nb - 1);
    lane = OUT_W'(shreg_q >> (k * bw)) & OUT_W'(lane_mask(size_q, OUT_W));
  end

  for (genvar j = 0; j < OUT_W / 8; j++) begin : g_rep
    assign rep[j] = (bw == 8)  ? lane[7:0] :
                    (bw == 16) ? lane[8*(j%2) +: 8] :
                                 lane[8*(j%4) +: 8];
  end

  assign bus.out_data  = rep;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_beat  = beat_q;
  assign bus.out_last  = last;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pop       = 1'b0;
    load      = 1'b0;
    load_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          load    = 1'b1;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (last) begin
            pop    = 1'b1;
            beat_d = '0;
            if (count > CW'(1)) begin
              load      = 1'b1;
              load_next = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      beat_d  = '0;
      load    = 1'b0;
      pop     = 1'b0;
    end
  end

  assign load_word = load_next ? nxt : head;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shreg_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (load) begin
        size_q  <= load_word[FW-1 -: 2];
        shreg_q <= load_word[IN_W-1:0];
      end
    end
  end
endmodule
